// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Slave end of the core's mem_valid / mem_ready load/store port. Holds a
//   word-organised SRAM of DEPTH 32-bit words mapped at byte address BASE and
//   serves one access at a time after LATENCY wait states.
//
//   Sequence per access: IDLE (accept + latch) -> WAIT (LATENCY cycles,
//   skipped when LATENCY=0) -> RESP (one cycle, access performed). The
//   registered response outputs are loaded on the edge that leaves RESP, so
//   mem_ready is seen LATENCY+1 cycles after the accept edge (1 cycle when
//   LATENCY=0). Minimum spacing is one access per LATENCY+2 cycles.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-low reset (SRAM contents are kept)
//   mem_valid  in   request present, held by initiator until mem_ready
//   mem_addr   in   byte address (XLEN)
//   mem_wdata  in   store data, byte lanes aligned to addr[1:0]
//   mem_wstrb  in   byte write enables, 4'b0000 = load
//   mem_rdata  out  load data, non-zero only while mem_ready=1
//   mem_ready  out  single-cycle completion pulse
//   mem_error  out  access fault, qualified by mem_ready
//
// Optional feature (compile-time macro DMEM_MISALIGN_CHECK_EN):
//   defined     -> strobe patterns / addresses that are not naturally aligned
//                  are answered with mem_error=1 and never write.
//   not defined -> strobes are applied as given, addr[1:0] is ignored and
//                  mem_error reflects the address range only.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int              XLEN    = 32,
    parameter int              DEPTH   = 1024,
    parameter logic [XLEN-1:0] BASE    = 32'h0001_0000,
    parameter int              LATENCY = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            mem_valid,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_wdata,
    input  logic [3:0]      mem_wstrb,
    output logic [XLEN-1:0] mem_rdata,
    output logic            mem_ready,
    output logic            mem_error
);

    localparam int              IDXW  = $clog2(DEPTH);
    localparam logic [3:0]      LAT4  = 4'(LATENCY);
    // One bit wider than the address so BASE+span cannot wrap.
    localparam logic [XLEN:0]   LIMIT = {1'b0, BASE} + (XLEN+1)'(DEPTH * 4);

    // Elaboration-time parameter sanity checks.
    if ((LATENCY < 0) || (LATENCY > 15)) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be in 0..15");
    end
    if ((DEPTH < 1) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("dmem_responder: DEPTH must be a power of two");
    end
    if (BASE[IDXW+1:0] != '0) begin : g_bad_base
        $error("dmem_responder: BASE must be DEPTH*4 aligned");
    end
    if (XLEN != 32) begin : g_bad_xlen
        $error("dmem_responder: four byte strobes require XLEN=32");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_cnt;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [3:0]      r_wstrb;
    logic [XLEN-1:0] r_rdata;
    logic            r_ready;
    logic            r_error;

    logic [31:0]     r_mem [DEPTH];

    logic            w_in_range;
    logic            w_misalign;
    logic [IDXW-1:0] w_idx;
    logic            w_we;
    logic            w_ready_nxt;
    logic            w_error_nxt;
    logic [XLEN-1:0] w_rdata_nxt;

`ifdef DMEM_MISALIGN_CHECK_EN
    // True when the strobe pattern is not a naturally aligned byte, halfword
    // or word, or its lowest set lane differs from addr[1:0]. Loads only
    // fault on an odd address.
    function automatic logic misaligned(input logic [1:0] a, input logic [3:0] s);
        logic bad;
        case (s)
            4'b0000: bad = a[0];
            4'b0001: bad = (a != 2'd0);
            4'b0010: bad = (a != 2'd1);
            4'b0100: bad = (a != 2'd2);
            4'b1000: bad = (a != 2'd3);
            4'b0011: bad = (a != 2'd0);
            4'b1100: bad = (a != 2'd2);
            4'b1111: bad = (a != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    assign w_misalign = misaligned(r_addr[1:0], r_wstrb);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_in_range = (r_addr >= BASE) && ({1'b0, r_addr} < LIMIT);
    assign w_idx      = r_addr[IDXW+1:2];

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a WAIT counter at 0 or 1 both exit so a corrupted
    // counter can never strand the FSM in WAIT.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (mem_valid) begin
                    w_state_nxt = (LAT4 == 4'd0) ? S_RESP : S_WAIT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request latch and wait-state counter; inputs are only sampled in IDLE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mem_valid) begin
                        r_cnt   <= LAT4;
                        r_addr  <= mem_addr;
                        r_wdata <= mem_wdata;
                        r_wstrb <= mem_wstrb;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Response decode: only RESP produces a response or a write.
    always_comb begin
        w_we        = 1'b0;
        w_ready_nxt = 1'b0;
        w_error_nxt = 1'b0;
        w_rdata_nxt = '0;
        if (r_state == S_RESP) begin
            w_ready_nxt = 1'b1;
            if (!w_in_range || w_misalign) begin
                w_error_nxt = 1'b1;
            end else if (r_wstrb == 4'b0000) begin
                w_rdata_nxt = r_mem[w_idx];
            end else begin
                w_we = 1'b1;
            end
        end else begin
            w_ready_nxt = 1'b0;
        end
    end

    // Registered response outputs; cleared immediately by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ready <= 1'b0;
            r_error <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= w_ready_nxt;
            r_error <= w_error_nxt;
            r_rdata <= w_rdata_nxt;
        end
    end

    // SRAM byte-lane write; contents deliberately survive reset. Reset forces
    // the FSM out of RESP, so an aborted access never writes.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (w_we && r_wstrb[i]) begin
                r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
    end

    assign mem_ready = r_ready;
    assign mem_error = r_error;
    assign mem_rdata = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. Instance 0 uses LATENCY=2,
// instance 1 uses LATENCY=0; expected data comes from a word-indexed
// associative-array memory model and the address/strobe rules.
module tb_dmem_responder;

    localparam logic [31:0] BASE = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v   [2];
    logic [31:0] a   [2];
    logic [31:0] wd  [2];
    logic [3:0]  ws  [2];
    logic [31:0] rd  [2];
    logic        rdy [2];
    logic        err [2];

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [int];

    dmem_responder #(.XLEN(32), .DEPTH(1024), .BASE(BASE), .LATENCY(2)) u_dut_l2 (
        .clock(clk), .reset(rst_n), .mem_valid(v[0]), .mem_addr(a[0]),
        .mem_wdata(wd[0]), .mem_wstrb(ws[0]), .mem_rdata(rd[0]),
        .mem_ready(rdy[0]), .mem_error(err[0])
    );

    dmem_responder #(.XLEN(32), .DEPTH(1024), .BASE(BASE), .LATENCY(0)) u_dut_l0 (
        .clock(clk), .reset(rst_n), .mem_valid(v[1]), .mem_addr(a[1]),
        .mem_wdata(wd[1]), .mem_wstrb(ws[1]), .mem_rdata(rd[1]),
        .mem_ready(rdy[1]), .mem_error(err[1])
    );

    always #5 clk = ~clk;

    function automatic int exp_lat(input int d);
        return (d == 0) ? 3 : 1;
    endfunction

    function automatic logic in_rng(input logic [31:0] x);
        return (x >= BASE) && (x < BASE + 32'd4096);
    endfunction

    function automatic logic model_fault(input logic [31:0] x, input logic [3:0] s);
        if (!in_rng(x)) return 1'b1;
`ifdef DMEM_MISALIGN_CHECK_EN
        if (s == 4'd0) return x[0];
        if (!(s inside {4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd12, 4'd15})) return 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) return (i != int'(x[1:0]));
        end
`endif
        return 1'b0;
    endfunction

    function automatic int mkey(input int d, input logic [31:0] x);
        return d * 4096 + int'((x - BASE) >> 2);
    endfunction

    task automatic model_store(input int d, input logic [31:0] x, input logic [31:0] dat,
                               input logic [3:0] s);
        logic [31:0] w;
        w = model.exists(mkey(d, x)) ? model[mkey(d, x)] : 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) w[8*i +: 8] = dat[8*i +: 8];
        end
        model[mkey(d, x)] = w;
    endtask

    // Drive one request, wait (bounded) for mem_ready, then release it and
    // sample the cycle after the pulse. lat = -1 means no response seen.
    task automatic access(input int d, input logic [31:0] x, input logic [31:0] dat,
                          input logic [3:0] s, output logic [31:0] o_rd,
                          output logic o_err, output int lat, output logic after);
        @(negedge clk);
        v[d] = 1'b1; a[d] = x; wd[d] = dat; ws[d] = s;
        @(posedge clk);
        lat = -1; o_rd = 32'd0; o_err = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (rdy[d] === 1'b1) begin
                lat = k; o_rd = rd[d]; o_err = err[d];
                break;
            end
        end
        v[d] = 1'b0;
        @(negedge clk);
        after = rdy[d];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            v[d] = 1'b0; a[d] = 32'd0; wd[d] = 32'd0; ws[d] = 4'd0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++; if (rdy[d] !== 1'b0) begin failures++; $display("FAIL reset_ready[%0d]: got %b want 0", d, rdy[d]); end
            checks++; if (err[d] !== 1'b0) begin failures++; $display("FAIL reset_error[%0d]: got %b want 0", d, err[d]); end
            checks++; if (rd[d] !== 32'd0) begin failures++; $display("FAIL reset_rdata[%0d]: got %h want 0", d, rd[d]); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_roundtrip();
        logic [31:0] r; logic e, af; int l;
        access(0, 32'h0001_0010, 32'hDEAD_BEEF, 4'b1111, r, e, l, af);
        checks++; if (l !== 3) begin failures++; $display("FAIL rt_store_latency: got %0d want 3", l); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL rt_store_error: got %b want 0", e); end
        checks++; if (r !== 32'd0) begin failures++; $display("FAIL rt_store_rdata: got %h want 0", r); end
        checks++; if (af !== 1'b0) begin failures++; $display("FAIL rt_pulse_width: ready still %b after pulse", af); end
        access(0, 32'h0001_0010, 32'd0, 4'b0000, r, e, l, af);
        checks++; if (r !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rt_load_rdata: got %h want deadbeef", r); end
        checks++; if (e !== 1'b0 || l !== 3) begin failures++; $display("FAIL rt_load_resp: err %b lat %0d want 0/3", e, l); end
    endtask

    task automatic test_byte_strobe();
        logic [31:0] r; logic e, af; int l;
        access(0, 32'h0001_0011, 32'h0000_AA00, 4'b0010, r, e, l, af);
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL strobe_store_error: got %b want 0", e); end
        access(0, 32'h0001_0010, 32'd0, 4'b0000, r, e, l, af);
        checks++; if (r !== 32'hDEAD_AAEF) begin failures++; $display("FAIL strobe_load: got %h want deadaaef", r); end
    endtask

    task automatic test_range_fault();
        logic [31:0] r; logic e, af; int l;
        access(0, 32'h0001_0000, 32'hCAFE_F00D, 4'b1111, r, e, l, af);
        access(0, 32'h0000_FFFC, 32'd0, 4'b0000, r, e, l, af);
        checks++; if (l !== 3 || e !== 1'b1) begin failures++; $display("FAIL range_low_load: lat %0d err %b want 3/1", l, e); end
        checks++; if (r !== 32'd0) begin failures++; $display("FAIL range_low_rdata: got %h want 0", r); end
        access(0, 32'h0001_1000, 32'h5555_5555, 4'b1111, r, e, l, af);
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL range_high_store: err %b want 1", e); end
        access(0, 32'h0001_0000, 32'd0, 4'b0000, r, e, l, af);
        checks++; if (r !== 32'hCAFE_F00D) begin failures++; $display("FAIL range_no_alias_write: got %h want cafef00d", r); end
        // Last mapped word is still in range.
        access(0, 32'h0001_0FFC, 32'h1357_9BDF, 4'b1111, r, e, l, af);
        access(0, 32'h0001_0FFC, 32'd0, 4'b0000, r, e, l, af);
        checks++; if (r !== 32'h1357_9BDF || e !== 1'b0) begin failures++; $display("FAIL range_top_word: got %h err %b want 13579bdf/0", r, e); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, d1, d2, exp; logic e, af; int l, pulses;
        int at [$];
        d1 = $urandom; d2 = $urandom;
        access(1, 32'h0001_0100, d1, 4'b1111, r, e, l, af);
        checks++; if (l !== 1) begin failures++; $display("FAIL lat0_latency: got %0d want 1", l); end
        access(1, 32'h0001_0104, d2, 4'b1111, r, e, l, af);
        // Hold mem_valid high; switch address as soon as the first ready is seen.
        @(negedge clk);
        v[1] = 1'b1; a[1] = 32'h0001_0100; ws[1] = 4'b0000;
        @(posedge clk);
        pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (rdy[1] === 1'b1) begin
                pulses++;
                at.push_back(k);
                exp = (pulses == 1) ? d1 : d2;
                checks++; if (rd[1] !== exp) begin failures++; $display("FAIL held_rdata%0d: got %h want %h", pulses, rd[1], exp); end
                if (pulses == 1) a[1] = 32'h0001_0104;
                else v[1] = 1'b0;
            end
        end
        v[1] = 1'b0;
        checks++; if (pulses !== 2) begin failures++; $display("FAIL held_pulse_count: got %0d want 2", pulses); end
        if (at.size() == 2) begin
            checks++; if (at[0] !== 1 || at[1] !== 3) begin failures++; $display("FAIL held_spacing: pulses at %0d,%0d want 1,3", at[0], at[1]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; logic e, af; int l, stray, seen;
        access(0, 32'h0001_0020, 32'h0BAD_F00D, 4'b1111, r, e, l, af);
        @(negedge clk);
        v[0] = 1'b1; a[0] = 32'h0001_0020; wd[0] = 32'h1234_5678; ws[0] = 4'b1111;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            if (rdy[0] !== 1'b0 || err[0] !== 1'b0 || rd[0] !== 32'd0) stray++;
        end
        v[0] = 1'b0;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rdy[0] !== 1'b0) stray++;
        end
        checks++; if (stray !== 0) begin failures++; $display("FAIL rstmid_no_response: %0d bad samples want 0", stray); end
        access(0, 32'h0001_0020, 32'd0, 4'b0000, r, e, l, af);
        checks++; if (r !== 32'h0BAD_F00D) begin failures++; $display("FAIL rstmid_no_write: got %h want 0badf00d", r); end
        // Reset while the response is on the outputs must clear them at once.
        @(negedge clk);
        v[0] = 1'b1; a[0] = 32'h0001_0020; ws[0] = 4'b0000;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rdy[0] === 1'b1) begin seen = 1; break; end
        end
        checks++; if (seen !== 1 || rd[0] !== 32'h0BAD_F00D) begin failures++; $display("FAIL rstasync_pre: seen %0d rdata %h want 1/0badf00d", seen, rd[0]); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (rdy[0] !== 1'b0 || rd[0] !== 32'd0) begin failures++; $display("FAIL rstasync_clear: ready %b rdata %h want 0/0", rdy[0], rd[0]); end
        v[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_misalign();
        logic [31:0] r, exp_w; logic e, af, exp_e; int l;
        access(0, 32'h0001_0001, 32'hAABB_CCDD, 4'b0110, r, e, l, af);
`ifdef DMEM_MISALIGN_CHECK_EN
        exp_e = 1'b1; exp_w = 32'hCAFE_F00D;
`else
        exp_e = 1'b0; exp_w = 32'hCABB_CC0D;
`endif
        checks++; if (e !== exp_e) begin failures++; $display("FAIL misalign_error: got %b want %b", e, exp_e); end
        access(0, 32'h0001_0000, 32'd0, 4'b0000, r, e, l, af);
        checks++; if (r !== exp_w) begin failures++; $display("FAIL misalign_word: got %h want %h", r, exp_w); end
    endtask

    task automatic test_random();
        logic [31:0] r, x, dat, exp_r; logic e, af, f; logic [3:0] s; int l;
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 8; w++) begin
                dat = $urandom;
                access(d, 32'h0001_0200 + 32'(w * 4), dat, 4'b1111, r, e, l, af);
                model_store(d, 32'h0001_0200 + 32'(w * 4), dat, 4'b1111);
            end
            for (int n = 0; n < 40; n++) begin
                case ($urandom_range(0, 9))
                    0:       x = 32'h0000_FFFC + 32'($urandom_range(0, 3));
                    1:       x = 32'h0001_1000 + 32'($urandom_range(0, 255));
                    2:       x = $urandom | 32'h8000_0000;
                    default: x = 32'h0001_0200 + 32'($urandom_range(0, 31));
                endcase
                s   = ($urandom_range(0, 9) < 4) ? 4'd0 : 4'($urandom_range(1, 15));
                dat = $urandom;
                f   = model_fault(x, s);
                exp_r = (f || s != 4'd0) ? 32'd0 : model[mkey(d, x)];
                access(d, x, dat, s, r, e, l, af);
                if (!f && s != 4'd0) model_store(d, x, dat, s);
                checks++;
                if (l !== exp_lat(d) || e !== f || r !== exp_r || af !== 1'b0) begin
                    failures++;
                    $display("FAIL rand[%0d.%0d] addr %h strb %b: lat %0d err %b rdata %h after %b want %0d/%b/%h/0",
                             d, n, x, s, l, e, r, af, exp_lat(d), f, exp_r);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_roundtrip();
        test_byte_strobe();
        test_range_fault();
        test_back_to_back();
        test_reset_mid();
        test_misalign();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the core's load/store port; the slave end of the mem_valid / mem_ready protocol that the pipeline drives for loads and stores.
- Holds a word-organised SRAM array of DEPTH 32-bit words at a fixed base address.
- Serves one access at a time after a programmable number of wait states.
- Returns mem_rdata and mem_ready, plus mem_error for accesses outside the mapped range.

Parameters:
- XLEN, 32, data and address width.
- DEPTH, 1024, number of 32-bit words; must be a power of two.
- BASE, 32'h0001_0000, byte base address of the array; DEPTH*4-aligned.
- LATENCY, 2, wait-state cycles between accept and response (0..15).

Ports:
- reset  in  1  asynchronous active-low reset
- clock  in  1  rising-edge clock
- mem_valid  in  1  request present; held by initiator until mem_ready
- mem_addr  in  XLEN  byte address
- mem_wdata  in  XLEN  store data, byte lanes aligned to addr[1:0]
- mem_wstrb  in  4  byte write enables; 4'b0000 = load
- mem_rdata  out  XLEN  load data, full word; valid only while mem_ready=1
- mem_ready  out  1  single-cycle completion pulse
- mem_error  out  1  access fault; qualified by mem_ready

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, wait counter=0, latched request cleared.
  - mem_ready=0, mem_error=0, mem_rdata=0.
  - SRAM contents are NOT reset.
  - Reset asserted mid-access aborts the access: no write occurs and no response is issued.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If mem_valid=1: latch addr, wdata, wstrb; load counter=LATENCY.
  - Go to WAIT if LATENCY>0, else go to RESP.
  - mem_valid=0: remain in IDLE.
- WAIT:
  - Decrement the counter each cycle.
  - When counter==1, go to RESP.
  - mem_valid and the request inputs are ignored; the latched copy is used.
- RESP (exactly one cycle):
  - Perform the access and drive mem_ready=1, then return to IDLE.
  - No request is accepted in this cycle. The initiator sees ready and drops or changes its request the following cycle.
  - Minimum spacing is one access per LATENCY+2 cycles.
- Latency from accept edge to mem_ready high:
  - LATENCY=0: 1 cycle.
  - Otherwise: LATENCY+1 cycles.
- Address decode:
  - in_range = (addr >= BASE) && (addr < BASE+DEPTH*4).
  - Word index = addr[log2(DEPTH)+1:2]; addr[1:0] is ignored for indexing.
- Load (wstrb=0, in range): mem_rdata = array[index]; mem_error=0.
- Store (wstrb!=0, in range):
  - For each i with wstrb[i]=1, array[index][8i+7:8i] = wdata[8i+7:8i].
  - mem_rdata=0, mem_error=0.
- Out of range: no write; mem_rdata=0; mem_error=1 with mem_ready=1.
- Outside RESP, mem_ready=0, mem_error=0, mem_rdata=0. All three are registered outputs.
- Counter is 4 bits. LATENCY>15 is illegal and is caught by an elaboration check.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN
- Defined: the responder checks alignment in RESP.
  - A request is misaligned if wstrb is not one of 0001/0010/0100/1000/0011/1100/1111, or if wstrb is inconsistent with addr[1:0]. Consistent means the lowest set strobe bit equals addr[1:0].
  - A non-zero wstrb that is misaligned gets mem_error=1, mem_ready=1, and no write.
  - A load with addr[0]=1 also gets mem_error=1.
- Not defined: strobes are applied as given, addr[1:0] is ignored, and mem_error reflects range only.

Test Plan:
- Store/load round trip:
  - Reset, LATENCY=2. Store addr=0x00010010, wdata=0xDEADBEEF, wstrb=1111 → mem_ready pulses exactly 3 cycles after accept, mem_error=0.
  - Then load 0x00010010 → mem_rdata=0xDEADBEEF on the ready cycle.
- Byte strobe: after the above, store wdata=0x0000AA00, wstrb=0010 to 0x00010011 → subsequent load of 0x00010010 returns 0xDEADAAEF.
- Range fault:
  - Load 0x0000FFFC → mem_ready=1, mem_error=1, mem_rdata=0.
  - Store 0x00011000 (DEPTH=1024) → error, and the word at 0x00010000 is unchanged.
- Held request and LATENCY=0:
  - mem_valid held high continuously across two different loads → each mem_ready pulse lasts exactly one cycle.
  - The second access is accepted only in the IDLE cycle after RESP; spacing is 2 cycles.
- Reset mid-access: assert reset during WAIT of a store to 0x00010020 wdata=0x12345678 → no mem_ready, outputs 0 immediately; a later load of 0x00010020 returns the prior value.
- With DMEM_MISALIGN_CHECK_EN: store wstrb=0110 at 0x00010001 → mem_error=1, no write. Without the macro → write applied and mem_error=0.
